// File: rtl/trigger_unit_if.sv
// Bundle of trigger sources, control pulses and capture status for trigger_unit.
// The slave modport is the trigger unit; the master modport drives it.
interface trigger_unit_if #(
   parameter int NUM_CH = 5,
   parameter int CNT_W  = 9
);
   logic [NUM_CH-1:0] i_ch_trig;
   logic [NUM_CH-1:0] i_ch_en;
   logic              i_prot_trig;
   logic              i_prot_en;
   logic              i_mode_or;
   logic              i_arm;
   logic              i_disarm;
   logic              i_smpl_en;
   logic [CNT_W-1:0]  i_post_cnt;
   logic              o_armed;
   logic              o_triggered;
   logic              o_capture_done;
   logic [CNT_W-1:0]  o_post_left;
   logic [NUM_CH:0]   o_trig_src;

   modport slave (
      input  i_ch_trig, i_ch_en, i_prot_trig, i_prot_en, i_mode_or,
      input  i_arm, i_disarm, i_smpl_en, i_post_cnt,
      output o_armed, o_triggered, o_capture_done, o_post_left, o_trig_src
   );

   modport master (
      output i_ch_trig, i_ch_en, i_prot_trig, i_prot_en, i_mode_or,
      output i_arm, i_disarm, i_smpl_en, i_post_cnt,
      input  o_armed, o_triggered, o_capture_done, o_post_left, o_trig_src
   );
endinterface

// File: rtl/trigger_unit.sv
// Capture trigger: masked AND/OR of channel + protocol triggers, arm -> trigger -> post count -> done.
// Optional feature macro TRIG_QUAL_EN: trigger only after QUAL_CYC consecutive cycles of cond.
module trigger_unit #(
   parameter int NUM_CH   = 5,
   parameter int CNT_W    = 9,
   parameter int QUAL_CYC = 4
) (
   input  logic           i_clk,
   input  logic           i_rst,
   trigger_unit_if.slave  bus
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_POST  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [NUM_CH:0]   SRC_ZERO = {(NUM_CH+1){1'b0}};

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_armed;
   logic              r_triggered;
   logic              r_done;
   logic [CNT_W-1:0]  r_post_left;
   logic [NUM_CH:0]   r_trig_src;
   logic              w_trig_nxt;
   logic              w_done_nxt;
   logic [CNT_W-1:0]  w_left_nxt;
   logic [NUM_CH:0]   w_src_nxt;
   logic [NUM_CH:0]   w_src;
   logic [NUM_CH:0]   w_en;
   logic              w_cond;
   logic              w_fire;

   // Masked sources and the AND/OR combination; nothing enabled never triggers
   always_comb begin
      w_src  = {bus.i_prot_trig & bus.i_prot_en, bus.i_ch_trig & bus.i_ch_en};
      w_en   = {bus.i_prot_en, bus.i_ch_en};
      w_cond = 1'b0;
      if (w_en == SRC_ZERO) begin
         w_cond = 1'b0;
      end else if (bus.i_mode_or) begin
         w_cond = |w_src;
      end else begin
         w_cond = &(w_src | ~w_en);
      end
   end

`ifdef TRIG_QUAL_EN
   localparam int QW = $clog2(QUAL_CYC + 1);
   localparam logic [QW-1:0] QUAL_LAST = QW'(QUAL_CYC - 1);
   localparam logic [QW-1:0] QUAL_MAX  = QW'(QUAL_CYC);

   logic [QW-1:0] r_qual;
   logic [QW-1:0] w_qual_nxt;

   // Run-length of cond while armed; any gap or leaving ARMED restarts it
   always_comb begin
      w_fire     = w_cond && (r_qual >= QUAL_LAST);
      w_qual_nxt = {QW{1'b0}};
      if ((r_state == ST_ARMED) && w_cond && !bus.i_disarm) begin
         if (r_qual < QUAL_MAX) begin
            w_qual_nxt = r_qual + QW'(1);
         end else begin
            w_qual_nxt = r_qual;
         end
      end else begin
         w_qual_nxt = {QW{1'b0}};
      end
   end

   // Qualification counter register
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_qual <= {QW{1'b0}};
      end else begin
         r_qual <= w_qual_nxt;
      end
   end
`else
   // Without qualification a single cycle of cond is enough
   always_comb begin
      w_fire = w_cond;
   end
`endif

   // Next state and next values of every registered output; disarm has top priority
   always_comb begin
      w_state_nxt = r_state;
      w_trig_nxt  = r_triggered;
      w_done_nxt  = r_done;
      w_left_nxt  = r_post_left;
      w_src_nxt   = r_trig_src;
      if (bus.i_disarm) begin
         w_state_nxt = ST_IDLE;
         w_trig_nxt  = 1'b0;
         w_done_nxt  = 1'b0;
         w_left_nxt  = CNT_ZERO;
         w_src_nxt   = SRC_ZERO;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.i_arm) begin
                  w_state_nxt = ST_ARMED;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_ARMED: begin
               if (w_fire) begin
                  w_state_nxt = ST_POST;
                  w_trig_nxt  = 1'b1;
                  w_left_nxt  = bus.i_post_cnt;
                  w_src_nxt   = w_src;
               end else begin
                  w_state_nxt = ST_ARMED;
               end
            end
            ST_POST: begin
               // A zero count finishes without waiting for a sample strobe
               if (r_post_left == CNT_ZERO) begin
                  w_state_nxt = ST_DONE;
                  w_done_nxt  = 1'b1;
               end else if (bus.i_smpl_en) begin
                  if (r_post_left == CNT_ONE) begin
                     w_state_nxt = ST_DONE;
                     w_done_nxt  = 1'b1;
                     w_left_nxt  = CNT_ZERO;
                  end else begin
                     w_left_nxt  = r_post_left - CNT_ONE;
                  end
               end else begin
                  w_state_nxt = ST_POST;
               end
            end
            ST_DONE: begin
               if (bus.i_arm) begin
                  w_state_nxt = ST_ARMED;
                  w_trig_nxt  = 1'b0;
                  w_done_nxt  = 1'b0;
                  w_left_nxt  = CNT_ZERO;
                  w_src_nxt   = SRC_ZERO;
               end else begin
                  w_state_nxt = ST_DONE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_trig_nxt  = 1'b0;
               w_done_nxt  = 1'b0;
               w_left_nxt  = CNT_ZERO;
               w_src_nxt   = SRC_ZERO;
            end
         endcase
      end
   end

   // State and output registers
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_armed     <= 1'b0;
         r_triggered <= 1'b0;
         r_done      <= 1'b0;
         r_post_left <= CNT_ZERO;
         r_trig_src  <= SRC_ZERO;
      end else begin
         r_state     <= w_state_nxt;
         r_armed     <= (w_state_nxt == ST_ARMED);
         r_triggered <= w_trig_nxt;
         r_done      <= w_done_nxt;
         r_post_left <= w_left_nxt;
         r_trig_src  <= w_src_nxt;
      end
   end

   assign bus.o_armed        = r_armed;
   assign bus.o_triggered    = r_triggered;
   assign bus.o_capture_done = r_done;
   assign bus.o_post_left    = r_post_left;
   assign bus.o_trig_src     = r_trig_src;
endmodule

// File: tb/tb_trigger_unit.sv
// Directed bench for trigger_unit: linear stimulus, hand-computed expectations, immediate assertions.
module tb_trigger_unit;
   localparam int NUM_CH = 5;
   localparam int CNT_W  = 9;
`ifdef TRIG_QUAL_EN
   localparam int QUAL = 4;
`else
   localparam int QUAL = 1;
`endif

   logic clk;
   logic rst;
   int   n_assert;
   int   n_fail;

   trigger_unit_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) u_if ();

   trigger_unit #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .QUAL_CYC(4)) u_dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (u_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Hold current inputs for the extra cycles qualification needs before the trigger edge
   task automatic qual_pre();
      for (int i = 0; i < QUAL - 1; i++) tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic a, input logic t, input logic d,
                          input logic [CNT_W-1:0] l, input logic [NUM_CH:0] s);
      chk({tag, ".armed"},     {31'd0, u_if.o_armed},        {31'd0, a});
      chk({tag, ".triggered"}, {31'd0, u_if.o_triggered},    {31'd0, t});
      chk({tag, ".done"},      {31'd0, u_if.o_capture_done}, {31'd0, d});
      chk({tag, ".post_left"}, {23'd0, u_if.o_post_left},    {23'd0, l});
      chk({tag, ".trig_src"},  {26'd0, u_if.o_trig_src},     {26'd0, s});
   endtask

   initial begin
      n_assert = 0;
      n_fail   = 0;
      rst = 1'b1;
      u_if.i_ch_trig   = 5'b00000;
      u_if.i_ch_en     = 5'b00000;
      u_if.i_prot_trig = 1'b0;
      u_if.i_prot_en   = 1'b0;
      u_if.i_mode_or   = 1'b0;
      u_if.i_arm       = 1'b0;
      u_if.i_disarm    = 1'b0;
      u_if.i_smpl_en   = 1'b0;
      u_if.i_post_cnt  = 9'd0;
      tick();
      tick();
      chk_all("reset", 1'b0, 1'b0, 1'b0, 9'd0, 6'b000000);
      rst = 1'b0;
      tick();
      chk_all("idle", 1'b0, 1'b0, 1'b0, 9'd0, 6'b000000);

      // AND mode, channels 0 and 2 enabled
      u_if.i_ch_en = 5'b00101;
      u_if.i_arm   = 1'b1;
      tick();
      u_if.i_arm = 1'b0;
      chk_all("and_armed", 1'b1, 1'b0, 1'b0, 9'd0, 6'b000000);
      u_if.i_ch_trig = 5'b00001;
      tick();
      tick();
      chk_all("and_partial", 1'b1, 1'b0, 1'b0, 9'd0, 6'b000000);
      u_if.i_ch_trig  = 5'b10101;
      u_if.i_post_cnt = 9'd3;
      qual_pre();
      tick();
      chk_all("and_trig", 1'b0, 1'b1, 1'b0, 9'd3, 6'b000101);
      u_if.i_ch_trig  = 5'b00000;
      u_if.i_post_cnt = 9'd7;
      u_if.i_smpl_en  = 1'b1;
      tick();
      chk("and_smpl1", {23'd0, u_if.o_post_left}, 32'd2);
      u_if.i_smpl_en = 1'b0;
      tick();
      chk("and_nosmpl", {23'd0, u_if.o_post_left}, 32'd2);
      u_if.i_smpl_en = 1'b1;
      tick();
      chk_all("and_smpl2", 1'b0, 1'b1, 1'b0, 9'd1, 6'b000101);
      tick();
      chk_all("and_done", 1'b0, 1'b1, 1'b1, 9'd0, 6'b000101);
      tick();
      chk_all("and_done_hold", 1'b0, 1'b1, 1'b1, 9'd0, 6'b000101);
      u_if.i_smpl_en = 1'b0;

      // Re-arm from DONE, then no enables -> never triggers in either mode
      u_if.i_arm = 1'b1;
      tick();
      u_if.i_arm = 1'b0;
      chk_all("rearm", 1'b1, 1'b0, 1'b0, 9'd0, 6'b000000);
      u_if.i_ch_en     = 5'b00000;
      u_if.i_ch_trig   = 5'b11111;
      u_if.i_prot_trig = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk_all("noen_and", 1'b1, 1'b0, 1'b0, 9'd0, 6'b000000);
      u_if.i_mode_or = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      chk_all("noen_or", 1'b1, 1'b0, 1'b0, 9'd0, 6'b000000);

      // OR mode, protocol trigger only
      u_if.i_prot_en  = 1'b1;
      u_if.i_post_cnt = 9'd2;
      qual_pre();
      tick();
      u_if.i_prot_trig = 1'b0;
      chk_all("prot_trig", 1'b0, 1'b1, 1'b0, 9'd2, 6'b100000);
      tick();
      chk("prot_hold_left", {23'd0, u_if.o_post_left}, 32'd2);
      u_if.i_disarm = 1'b1;
      tick();
      u_if.i_disarm = 1'b0;
      chk_all("prot_disarm", 1'b0, 1'b0, 1'b0, 9'd0, 6'b000000);

      // post_cnt = 0; cond present in the arm cycle is not evaluated
      u_if.i_prot_en = 1'b0;
      u_if.i_ch_en   = 5'b00001;
      u_if.i_post_cnt = 9'd0;
      u_if.i_arm     = 1'b1;
      tick();
      u_if.i_arm = 1'b0;
      chk_all("zero_armcycle", 1'b1, 1'b0, 1'b0, 9'd0, 6'b000000);
      qual_pre();
      tick();
      u_if.i_ch_trig = 5'b00000;
      chk_all("zero_trig", 1'b0, 1'b1, 1'b0, 9'd0, 6'b000001);
      tick();
      chk_all("zero_done", 1'b0, 1'b1, 1'b1, 9'd0, 6'b000001);
      u_if.i_arm = 1'b1;
      tick();
      u_if.i_arm = 1'b0;
      chk_all("zero_rearm", 1'b1, 1'b0, 1'b0, 9'd0, 6'b000000);

      // arm during POST ignored; disarm beats arm
      u_if.i_ch_trig  = 5'b00001;
      u_if.i_post_cnt = 9'd5;
      qual_pre();
      tick();
      chk_all("post_trig", 1'b0, 1'b1, 1'b0, 9'd5, 6'b000001);
      u_if.i_ch_trig = 5'b00000;
      u_if.i_arm     = 1'b1;
      u_if.i_smpl_en = 1'b1;
      tick();
      chk_all("post_arm_ign", 1'b0, 1'b1, 1'b0, 9'd4, 6'b000001);
      u_if.i_arm      = 1'b0;
      u_if.i_post_cnt = 9'd1;
      tick();
      chk("post_cnt_late", {23'd0, u_if.o_post_left}, 32'd3);
      u_if.i_disarm  = 1'b1;
      u_if.i_arm     = 1'b1;
      u_if.i_smpl_en = 1'b0;
      tick();
      chk_all("disarm_beats_arm", 1'b0, 1'b0, 1'b0, 9'd0, 6'b000000);
      u_if.i_disarm = 1'b0;
      u_if.i_arm    = 1'b0;
      tick();
      chk_all("disarm_idle", 1'b0, 1'b0, 1'b0, 9'd0, 6'b000000);

      // Asynchronous reset mid-capture
      u_if.i_arm = 1'b1;
      tick();
      u_if.i_arm      = 1'b0;
      u_if.i_ch_trig  = 5'b00001;
      u_if.i_post_cnt = 9'd4;
      qual_pre();
      tick();
      chk_all("rst_pre", 1'b0, 1'b1, 1'b0, 9'd4, 6'b000001);
      u_if.i_ch_trig = 5'b00000;
      #2;
      rst = 1'b1;
      #1;
      chk_all("rst_async", 1'b0, 1'b0, 1'b0, 9'd0, 6'b000000);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk_all("rst_after", 1'b0, 1'b0, 1'b0, 9'd0, 6'b000000);

`ifdef TRIG_QUAL_EN
      // Qualification: 3 high, 1 low, then 4 high before the trigger
      u_if.i_arm = 1'b1;
      tick();
      u_if.i_arm     = 1'b0;
      u_if.i_ch_trig = 5'b00001;
      for (int i = 0; i < 3; i++) tick();
      chk("qual_run3", {31'd0, u_if.o_triggered}, 32'd0);
      u_if.i_ch_trig = 5'b00000;
      tick();
      u_if.i_ch_trig = 5'b00001;
      for (int i = 0; i < 3; i++) tick();
      chk("qual_run3b", {31'd0, u_if.o_triggered}, 32'd0);
      tick();
      chk("qual_run4", {31'd0, u_if.o_triggered}, 32'd1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
